// File: rtl/crg_rst_seq.sv
// rtl/crg_rst_seq.sv - reset synchroniser, stretcher and ordered multi-domain reset release
// Optional watchdog built only when CRG_WDT_EN is defined.
module crg_rst_seq #(
  parameter int SYNC_STAGES    = 2,
  parameter int NUM_RST        = 3,
  parameter int STRETCH_CYCLES = 8,
  parameter int GAP_CYCLES     = 16,
  parameter int DIV_RATIO      = 4,
  parameter int WDT_CYCLES     = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               soft_rst,
  output logic [NUM_RST-1:0] rst_n_out,
  output logic               all_ready,
  output logic               ce_div,
  input  logic               wdt_kick,
  output logic               wdt_flag
);

  localparam int SW = $clog2(STRETCH_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int DW = $clog2(DIV_RATIO + 1);

  // Stretch releases on the edge after the counter has seen STRETCH_CYCLES
  // synced-high cycles; gap releases on its GAP_CYCLES-th edge.
  localparam logic [SW-1:0]      STRETCH_TC = SW'(STRETCH_CYCLES);
  localparam logic [GW-1:0]      GAP_TC     = GW'(GAP_CYCLES - 1);
  localparam logic [DW-1:0]      DIV_TC     = DW'(DIV_RATIO - 1);
  localparam logic [NUM_RST-1:0] LSB_ONE    = NUM_RST'(1);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_RELEASE,
    ST_DONE
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rst_sync;

  state_t                 state_q, state_d;
  logic [SW-1:0]          stretch_cnt_q, stretch_cnt_d;
  logic [GW-1:0]          gap_cnt_q, gap_cnt_d;
  logic [NUM_RST-1:0]     rst_n_out_q, rst_n_out_d;
  logic [NUM_RST-1:0]     rst_next;
  logic                   all_ready_q, all_ready_d;

  logic [DW-1:0]          div_cnt_q, div_cnt_d;
  logic                   ce_div_q, ce_div_d;

  logic                   wdt_fire;

  // Shift a constant one through the synchroniser; its last stage is the released reset.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], 1'b1};
    rst_sync = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Sequencer next state: stretch, then release one domain per gap, low bit first.
  always_comb begin
    state_d       = state_q;
    stretch_cnt_d = stretch_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    rst_n_out_d   = rst_n_out_q;
    all_ready_d   = all_ready_q;
    // Shifting a one in from the bottom keeps the release order monotonic.
    rst_next      = (rst_n_out_q << 1) | LSB_ONE;

    if (soft_rst || wdt_fire) begin
      state_d       = ST_ASSERT;
      stretch_cnt_d = '0;
      gap_cnt_d     = '0;
      rst_n_out_d   = '0;
      all_ready_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          rst_n_out_d = '0;
          all_ready_d = 1'b0;
          gap_cnt_d   = '0;
          if (!rst_sync) begin
            stretch_cnt_d = '0;
          end else if (stretch_cnt_q == STRETCH_TC) begin
            stretch_cnt_d = '0;
            rst_n_out_d   = rst_next;
            if (rst_next[NUM_RST-1]) begin
              state_d     = ST_DONE;
              all_ready_d = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            stretch_cnt_d = stretch_cnt_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (gap_cnt_q == GAP_TC) begin
            gap_cnt_d   = '0;
            rst_n_out_d = rst_next;
            if (rst_next[NUM_RST-1]) begin
              state_d     = ST_DONE;
              all_ready_d = 1'b1;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          all_ready_d = 1'b1;
        end
        default: begin
          state_d       = ST_ASSERT;
          stretch_cnt_d = '0;
          gap_cnt_d     = '0;
          rst_n_out_d   = '0;
          all_ready_d   = 1'b0;
        end
      endcase
    end
  end

  // Sequencer registers; outputs are flops so release can never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_ASSERT;
      stretch_cnt_q <= '0;
      gap_cnt_q     <= '0;
      rst_n_out_q   <= '0;
      all_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      stretch_cnt_q <= stretch_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      rst_n_out_q   <= rst_n_out_d;
      all_ready_q   <= all_ready_d;
    end
  end

  // Clock-enable divider, idle until the synchronised reset is released; soft reset does not touch it.
  always_comb begin
    div_cnt_d = div_cnt_q;
    ce_div_d  = 1'b0;
    if (rst_sync) begin
      if (div_cnt_q == DIV_TC) begin
        div_cnt_d = '0;
        ce_div_d  = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

  // Divider registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      ce_div_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      ce_div_q  <= ce_div_d;
    end
  end

`ifdef CRG_WDT_EN
  localparam int WW = $clog2(WDT_CYCLES + 1);
  localparam logic [WW-1:0] WDT_TC = WW'(WDT_CYCLES - 1);

  logic [WW-1:0] wdt_cnt_q, wdt_cnt_d;
  logic          wdt_flag_q, wdt_flag_d;

  // Watchdog counts only in DONE; a kick on the timeout cycle suppresses the reset.
  always_comb begin
    wdt_cnt_d  = '0;
    wdt_flag_d = wdt_flag_q;
    wdt_fire   = 1'b0;
    if (state_q == ST_DONE && !soft_rst) begin
      if (wdt_kick) begin
        wdt_cnt_d = '0;
      end else if (wdt_cnt_q == WDT_TC) begin
        wdt_fire   = 1'b1;
        wdt_flag_d = 1'b1;
      end else begin
        wdt_cnt_d = wdt_cnt_q + 1'b1;
      end
    end
  end

  // Watchdog registers; the flag is only cleared by the external reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_cnt_q  <= '0;
      wdt_flag_q <= 1'b0;
    end else begin
      wdt_cnt_q  <= wdt_cnt_d;
      wdt_flag_q <= wdt_flag_d;
    end
  end

  assign wdt_flag = wdt_flag_q;
`else
  logic unused_wdt;

  assign wdt_fire   = 1'b0;
  assign wdt_flag   = 1'b0;
  assign unused_wdt = wdt_kick ^ WDT_CYCLES[0];
`endif

  assign rst_n_out = rst_n_out_q;
  assign all_ready = all_ready_q;
  assign ce_div    = ce_div_q;

endmodule

// File: tb/tb_crg_rst_seq.sv
// tb/tb_crg_rst_seq.sv - directed self-checking bench for crg_rst_seq
module tb_crg_rst_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       soft_rst;
  logic       wdt_kick;
  logic [2:0] rst_n_out;
  logic       all_ready;
  logic       ce_div;
  logic       wdt_flag;

  logic       rst_n_b;
  logic [0:0] rst_n_out_b;
  logic       all_ready_b;
  logic       ce_div_b;
  logic       wdt_flag_b;

  int total  = 0;
  int bad    = 0;
  int t_edge = 0;

  always #5 clk = ~clk;

  crg_rst_seq #(
    .SYNC_STAGES(2), .NUM_RST(3), .STRETCH_CYCLES(8),
    .GAP_CYCLES(16), .DIV_RATIO(4), .WDT_CYCLES(64)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst), .rst_n_out(rst_n_out),
    .all_ready(all_ready), .ce_div(ce_div), .wdt_kick(wdt_kick), .wdt_flag(wdt_flag)
  );

  crg_rst_seq #(
    .SYNC_STAGES(2), .NUM_RST(1), .STRETCH_CYCLES(1),
    .GAP_CYCLES(16), .DIV_RATIO(1), .WDT_CYCLES(64)
  ) u_min (
    .clk(clk), .rst_n(rst_n_b), .soft_rst(1'b0), .rst_n_out(rst_n_out_b),
    .all_ready(all_ready_b), .ce_div(ce_div_b), .wdt_kick(1'b0), .wdt_flag(wdt_flag_b)
  );

  // Expected outputs k edges after T0 (defaults).
  function automatic logic [2:0] exp_seq(input int k);
    if (k < 10) return 3'b000;
    else if (k < 26) return 3'b001;
    else if (k < 42) return 3'b011;
    else return 3'b111;
  endfunction

  // Expected outputs j edges after a stretch restart whose first low soft sample is edge j=1.
  function automatic logic [2:0] exp_soft(input int j);
    if (j < 9) return 3'b000;
    else if (j < 25) return 3'b001;
    else if (j < 41) return 3'b011;
    else return 3'b111;
  endfunction

  function automatic logic exp_ce(input int k);
    return (k >= 5) && (((k - 5) % 4) == 0);
  endfunction

  task automatic step();
    @(negedge clk);
    t_edge++;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n  = 1'b1;
    t_edge = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst_n_b = 1'b0; soft_rst = 1'b0; wdt_kick = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (rst_n_out !== 3'b000) begin bad++; $display("FAIL reset_rst_n_out got=%b exp=000", rst_n_out); end
    total++; if (all_ready !== 1'b0) begin bad++; $display("FAIL reset_all_ready got=%b exp=0", all_ready); end
    total++; if (ce_div !== 1'b0) begin bad++; $display("FAIL reset_ce_div got=%b exp=0", ce_div); end
    total++; if (wdt_flag !== 1'b0) begin bad++; $display("FAIL reset_wdt_flag got=%b exp=0", wdt_flag); end
    total++; if (rst_n_out_b !== 1'b0) begin bad++; $display("FAIL reset_min_out got=%b exp=0", rst_n_out_b); end
  endtask

  task automatic test_sequence();
    release_rst();
    for (int k = 0; k <= 45; k++) begin
      step();
      total++;
      if (rst_n_out !== exp_seq(t_edge)) begin
        bad++; $display("FAIL seq_rst_n_out edge=T0+%0d got=%b exp=%b", t_edge, rst_n_out, exp_seq(t_edge));
      end
      total++;
      if (all_ready !== (t_edge >= 42)) begin
        bad++; $display("FAIL seq_all_ready edge=T0+%0d got=%b exp=%b", t_edge, all_ready, t_edge >= 42);
      end
      total++;
      if (ce_div !== exp_ce(t_edge)) begin
        bad++; $display("FAIL seq_ce_div edge=T0+%0d got=%b exp=%b", t_edge, ce_div, exp_ce(t_edge));
      end
    end
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    total++; if (rst_n_out !== 3'b000) begin bad++; $display("FAIL async_done_out got=%b exp=000", rst_n_out); end
    total++; if (all_ready !== 1'b0) begin bad++; $display("FAIL async_done_ready got=%b exp=0", all_ready); end
    total++; if (ce_div !== 1'b0) begin bad++; $display("FAIL async_done_ce got=%b exp=0", ce_div); end
    release_rst();
    while (t_edge < 20) step();
    total++; if (rst_n_out !== 3'b001) begin bad++; $display("FAIL async_mid_pre got=%b exp=001", rst_n_out); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (rst_n_out !== 3'b000) begin bad++; $display("FAIL async_mid_out got=%b exp=000", rst_n_out); end
    test_sequence();
  endtask

  task automatic test_soft_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    release_rst();
    while (t_edge < 30) step();
    total++; if (rst_n_out !== 3'b011) begin bad++; $display("FAIL soft_pulse_pre got=%b exp=011", rst_n_out); end
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    for (int j = 0; j <= 44; j++) begin
      if (j > 0) step();
      total++;
      if (rst_n_out !== exp_soft(j)) begin
        bad++; $display("FAIL soft_pulse_out edge=S+%0d got=%b exp=%b", j, rst_n_out, exp_soft(j));
      end
      total++;
      if (all_ready !== (j >= 41)) begin
        bad++; $display("FAIL soft_pulse_ready edge=S+%0d got=%b exp=%b", j, all_ready, j >= 41);
      end
      total++;
      if (ce_div !== exp_ce(t_edge)) begin
        bad++; $display("FAIL soft_pulse_ce edge=T0+%0d got=%b exp=%b", t_edge, ce_div, exp_ce(t_edge));
      end
    end
  endtask

  task automatic test_soft_hold();
    total++; if (rst_n_out !== 3'b111) begin bad++; $display("FAIL soft_hold_pre got=%b exp=111", rst_n_out); end
    soft_rst = 1'b1;
    for (int j = 0; j < 20; j++) begin
      step();
      total++;
      if (rst_n_out !== 3'b000 || all_ready !== 1'b0) begin
        bad++; $display("FAIL soft_hold_out cyc=%0d got=%b/%b exp=000/0", j, rst_n_out, all_ready);
      end
      total++;
      if (ce_div !== exp_ce(t_edge)) begin
        bad++; $display("FAIL soft_hold_ce edge=T0+%0d got=%b exp=%b", t_edge, ce_div, exp_ce(t_edge));
      end
    end
    soft_rst = 1'b0;
    for (int j = 0; j <= 10; j++) begin
      step();
      total++;
      if (rst_n_out !== ((j < 8) ? 3'b000 : 3'b001)) begin
        bad++; $display("FAIL soft_hold_release edge=S'+%0d got=%b exp=%b", j, rst_n_out, (j < 8) ? 3'b000 : 3'b001);
      end
    end
  endtask

  task automatic test_min_config();
    @(negedge clk);
    rst_n_b = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      total++;
      if (ce_div_b !== (k >= 2)) begin
        bad++; $display("FAIL min_ce edge=T0+%0d got=%b exp=%b", k, ce_div_b, k >= 2);
      end
      total++;
      if (rst_n_out_b[0] !== (k >= 3) || all_ready_b !== (k >= 3)) begin
        bad++; $display("FAIL min_release edge=T0+%0d got=%b/%b exp=%b", k, rst_n_out_b[0], all_ready_b, k >= 3);
      end
    end
    total++; if (wdt_flag_b !== 1'b0) begin bad++; $display("FAIL min_wdt_flag got=%b exp=0", wdt_flag_b); end
  endtask

`ifdef CRG_WDT_EN
  task automatic test_wdt();
    @(negedge clk);
    rst_n = 1'b0;
    release_rst();
    while (t_edge < 45) step();
    for (int n = 0; n < 4; n++) begin
      repeat (49) step();
      total++;
      if (rst_n_out !== 3'b111 || wdt_flag !== 1'b0) begin
        bad++; $display("FAIL wdt_kicked iter=%0d got=%b/%b exp=111/0", n, rst_n_out, wdt_flag);
      end
      wdt_kick = 1'b1;
      step();
      wdt_kick = 1'b0;
    end
    for (int j = 1; j <= 105; j++) begin
      step();
      if (j == 63) begin
        total++;
        if (rst_n_out !== 3'b111 || wdt_flag !== 1'b0) begin
          bad++; $display("FAIL wdt_before_fire got=%b/%b exp=111/0", rst_n_out, wdt_flag);
        end
      end
      if (j == 64) begin
        total++;
        if (rst_n_out !== 3'b000 || wdt_flag !== 1'b1) begin
          bad++; $display("FAIL wdt_fire got=%b/%b exp=000/1", rst_n_out, wdt_flag);
        end
      end
      if (j == 72 || j == 73) begin
        total++;
        if (rst_n_out !== ((j == 73) ? 3'b001 : 3'b000)) begin
          bad++; $display("FAIL wdt_reseq edge=K+%0d got=%b exp=%b", j, rst_n_out, (j == 73) ? 3'b001 : 3'b000);
        end
      end
    end
    total++;
    if (rst_n_out !== 3'b111 || wdt_flag !== 1'b1) begin
      bad++; $display("FAIL wdt_sticky got=%b/%b exp=111/1", rst_n_out, wdt_flag);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_async_reset();
    test_soft_pulse();
    test_soft_hold();
    test_min_config();
`ifdef CRG_WDT_EN
    test_wdt();
`endif
    total++;
    if (wdt_flag_b !== 1'b0) begin bad++; $display("FAIL final_min_wdt_flag got=%b exp=0", wdt_flag_b); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
